// File: rtl/lut_gate_pkg.sv
// Shared types and helpers for the programmable N-input LUT gate (lut_gate_seq).
package lut_gate_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SWEEP = 2'd2
  } state_e;

  localparam int N_IN_DEFAULT = 3;

  function automatic int depth_of(input int n);
    return 32'sd1 <<< n;
  endfunction

endpackage

// File: rtl/lut_gate_seq_if.sv
// Configuration, evaluation and sweep signals of lut_gate_seq.
// ones_cnt exists only when LUT_GATE_ONES_COUNT_EN is defined.
interface lut_gate_seq_if
  import lut_gate_pkg::*;
#(
  parameter int N_IN = N_IN_DEFAULT
) ();

  logic            cfg_start;
  logic            pos_mode;
  logic            cfg_bit_valid;
  logic            cfg_bit;
  logic            cfg_done;
  logic            tt_valid;
  logic            in_valid;
  logic [N_IN-1:0] in_vec;
  logic            in_ready;
  logic            sweep_start;
  logic            sweep_busy;
  logic            sweep_done;
  logic            out_valid;
  logic [N_IN-1:0] out_vec;
  logic            out_f;
`ifdef LUT_GATE_ONES_COUNT_EN
  logic [N_IN:0]   ones_cnt;
`endif

  modport master (
    output cfg_start, pos_mode, cfg_bit_valid, cfg_bit, in_valid, in_vec, sweep_start,
    input
`ifdef LUT_GATE_ONES_COUNT_EN
          ones_cnt,
`endif
          cfg_done, tt_valid, in_ready, sweep_busy, sweep_done, out_valid, out_vec, out_f
  );

  modport slave (
    input  cfg_start, pos_mode, cfg_bit_valid, cfg_bit, in_valid, in_vec, sweep_start,
    output
`ifdef LUT_GATE_ONES_COUNT_EN
           ones_cnt,
`endif
           cfg_done, tt_valid, in_ready, sweep_busy, sweep_done, out_valid, out_vec, out_f
  );

endinterface

// File: rtl/lut_gate_eval.sv
// Combinational truth-table lookup: a listed term gives F=1 in SOP mode, F=0 in POS mode.
module lut_gate_eval
  import lut_gate_pkg::*;
#(
  parameter  int N_IN  = N_IN_DEFAULT,
  localparam int DEPTH = depth_of(N_IN)
) (
  input  logic [DEPTH-1:0] mask,
  input  logic             pos,
  input  logic [N_IN-1:0]  vec,
  output logic             f
);

  assign f = mask[vec] ^ pos;

endmodule

// File: rtl/lut_gate_seq.sv
// Programmable N-input gate: serial mask load, single-vector evaluation and full-table sweep.
// Optional ones counter over sweep rows enabled by LUT_GATE_ONES_COUNT_EN.
module lut_gate_seq
  import lut_gate_pkg::*;
#(
  parameter int N_IN = N_IN_DEFAULT
) (
  input logic         clk,
  input logic         rst,
  lut_gate_seq_if.slave bus
);

  localparam int            DEPTH = depth_of(N_IN);
  localparam logic [N_IN:0] LAST  = (N_IN+1)'(DEPTH - 1);

  state_e           state_r;
  logic [DEPTH-1:0] mask_r;
  logic             pos_r;
  logic [N_IN:0]    cnt_r;
  logic [N_IN:0]    row_r;
  logic             wrap_r;
  logic             tt_valid_r;
  logic             cfg_done_r;
  logic             sweep_busy_r;
  logic             sweep_done_r;
  logic             out_valid_r;
  logic [N_IN-1:0]  out_vec_r;
  logic             out_f_r;
`ifdef LUT_GATE_ONES_COUNT_EN
  logic [N_IN:0]    ones_r;
`endif

  logic             sweep_go_s;
  logic             accept_s;
  logic [N_IN-1:0]  eval_vec_s;
  logic             f_s;

  // Command decode; row_r is 0 in IDLE, so a starting sweep looks up row 0.
  always_comb begin
    sweep_go_s = 1'b0;
    accept_s   = 1'b0;
    eval_vec_s = bus.in_vec;
    if (state_r == IDLE) begin
      sweep_go_s = bus.sweep_start & tt_valid_r & ~bus.cfg_start;
      accept_s   = bus.in_valid & tt_valid_r & ~bus.cfg_start & ~bus.sweep_start;
    end else begin
      sweep_go_s = 1'b0;
      accept_s   = 1'b0;
    end
    if ((state_r == SWEEP) || sweep_go_s) begin
      eval_vec_s = row_r[N_IN-1:0];
    end else begin
      eval_vec_s = bus.in_vec;
    end
  end

  lut_gate_eval #(.N_IN(N_IN)) u_eval (
    .mask (mask_r),
    .pos  (pos_r),
    .vec  (eval_vec_s),
    .f    (f_s)
  );

  // Control FSM with registered outputs; cfg_start overrides every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      mask_r       <= '0;
      pos_r        <= 1'b0;
      cnt_r        <= '0;
      row_r        <= '0;
      wrap_r       <= 1'b0;
      tt_valid_r   <= 1'b0;
      cfg_done_r   <= 1'b0;
      sweep_busy_r <= 1'b0;
      sweep_done_r <= 1'b0;
      out_valid_r  <= 1'b0;
      out_vec_r    <= '0;
      out_f_r      <= 1'b0;
`ifdef LUT_GATE_ONES_COUNT_EN
      ones_r       <= '0;
`endif
    end else begin
      cfg_done_r   <= 1'b0;
      sweep_done_r <= 1'b0;
      out_valid_r  <= 1'b0;
      if (bus.cfg_start) begin
        state_r      <= LOAD;
        cnt_r        <= '0;
        row_r        <= '0;
        wrap_r       <= 1'b0;
        tt_valid_r   <= 1'b0;
        pos_r        <= bus.pos_mode;
        sweep_busy_r <= 1'b0;
`ifdef LUT_GATE_ONES_COUNT_EN
        ones_r       <= '0;
`endif
      end else begin
        case (state_r)
          IDLE: begin
            if (sweep_go_s) begin
              state_r      <= SWEEP;
              sweep_busy_r <= 1'b1;
              row_r        <= (N_IN+1)'(1);
              out_valid_r  <= 1'b1;
              out_vec_r    <= eval_vec_s;
              out_f_r      <= f_s;
`ifdef LUT_GATE_ONES_COUNT_EN
              ones_r       <= {{N_IN{1'b0}}, f_s};
`endif
            end else if (accept_s) begin
              out_valid_r <= 1'b1;
              out_vec_r   <= eval_vec_s;
              out_f_r     <= f_s;
            end else begin
              out_valid_r <= 1'b0;
            end
          end
          LOAD: begin
            if (bus.cfg_bit_valid) begin
              mask_r[cnt_r[N_IN-1:0]] <= bus.cfg_bit;
              if (cnt_r == LAST) begin
                cnt_r      <= '0;
                cfg_done_r <= 1'b1;
                tt_valid_r <= 1'b1;
                state_r    <= IDLE;
              end else begin
                cnt_r <= cnt_r + (N_IN+1)'(1);
              end
            end else begin
              cnt_r <= cnt_r;
            end
          end
          SWEEP: begin
            // wrap_r marks the cycle after the last row has been emitted
            if (wrap_r) begin
              wrap_r       <= 1'b0;
              sweep_busy_r <= 1'b0;
              sweep_done_r <= 1'b1;
              state_r      <= IDLE;
            end else begin
              out_valid_r <= 1'b1;
              out_vec_r   <= eval_vec_s;
              out_f_r     <= f_s;
`ifdef LUT_GATE_ONES_COUNT_EN
              ones_r      <= ones_r + {{N_IN{1'b0}}, f_s};
`endif
              if (row_r == LAST) begin
                row_r  <= '0;
                wrap_r <= 1'b1;
              end else begin
                row_r <= row_r + (N_IN+1)'(1);
              end
            end
          end
          default: state_r <= IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready   = accept_s;
  assign bus.cfg_done   = cfg_done_r;
  assign bus.tt_valid   = tt_valid_r;
  assign bus.sweep_busy = sweep_busy_r;
  assign bus.sweep_done = sweep_done_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_vec    = out_vec_r;
  assign bus.out_f      = out_f_r;
`ifdef LUT_GATE_ONES_COUNT_EN
  assign bus.ones_cnt   = ones_r;
`endif

endmodule

// File: tb/tb_lut_gate_seq.sv
// Directed + randomized bench for lut_gate_seq (N_IN=3 and N_IN=8 instances) against a term-list model.
module tb_lut_gate_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lut_gate_seq_if #(.N_IN(3)) b3 ();
  lut_gate_seq_if #(.N_IN(8)) b8 ();

  lut_gate_seq #(.N_IN(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));
  lut_gate_seq #(.N_IN(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: the set of listed terms and the mode; SOP -> F=1 on listed, POS -> F=0 on listed.
  bit listed3 [8];
  bit pos3;
  bit listed8 [256];
  bit pos8;

  function automatic int ref3(input int i);
    return pos3 ? (listed3[i] ? 0 : 1) : (listed3[i] ? 1 : 0);
  endfunction

  function automatic int ref8(input int i);
    return pos8 ? (listed8[i] ? 0 : 1) : (listed8[i] ? 1 : 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_terms3(input int t0, input int t1, input int t2, input int t3, input int t4);
    for (int i = 0; i < 8; i++) listed3[i] = 1'b0;
    listed3[t0] = 1'b1; listed3[t1] = 1'b1; listed3[t2] = 1'b1;
    listed3[t3] = 1'b1; listed3[t4] = 1'b1;
  endtask

  task automatic load3(input bit do_start, input bit pos, input int gap_pct);
    if (do_start) begin
      b3.cfg_start = 1'b1;
      b3.pos_mode  = pos;
      tick();
      b3.cfg_start = 1'b0;
      chk("load_tt_cleared", b3.tt_valid, 0);
    end
    pos3 = pos;
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(99) < gap_pct) begin
        b3.cfg_bit_valid = 1'b0;
        tick();
      end
      b3.cfg_bit_valid = 1'b1;
      b3.cfg_bit       = listed3[i];
      tick();
      b3.cfg_bit_valid = 1'b0;
      if (i == 7) begin
        chk("cfg_done_last", b3.cfg_done, 1);
        chk("tt_valid_loaded", b3.tt_valid, 1);
      end else if (i == 3) begin
        chk("cfg_done_early", b3.cfg_done, 0);
        chk("tt_valid_midload", b3.tt_valid, 0);
        chk("no_sweep_done_load", b3.sweep_done, 0);
      end
    end
    tick();
    chk("cfg_done_pulse", b3.cfg_done, 0);
  endtask

  task automatic sweep3();
    int ones = 0;
    b3.sweep_start = 1'b1;
    tick();
    b3.sweep_start = 1'b0;
    for (int r = 0; r < 8; r++) begin
      chk("sweep_busy", b3.sweep_busy, 1);
      chk("sweep_valid", b3.out_valid, 1);
      chk("sweep_vec", b3.out_vec, r);
      chk("sweep_f", b3.out_f, ref3(r));
      ones += ref3(r);
      tick();
    end
    chk("sweep_done", b3.sweep_done, 1);
    chk("sweep_busy_end", b3.sweep_busy, 0);
    chk("sweep_valid_end", b3.out_valid, 0);
`ifdef LUT_GATE_ONES_COUNT_EN
    chk("ones_cnt", 32'(b3.ones_cnt), ones);
`endif
    tick();
    chk("sweep_done_pulse", b3.sweep_done, 0);
`ifdef LUT_GATE_ONES_COUNT_EN
    chk("ones_cnt_hold", 32'(b3.ones_cnt), ones);
`endif
  endtask

  initial begin
    rst = 1'b1;
    b3.cfg_start = 1'b0; b3.pos_mode = 1'b0; b3.cfg_bit_valid = 1'b0; b3.cfg_bit = 1'b0;
    b3.in_valid = 1'b0; b3.in_vec = '0; b3.sweep_start = 1'b0;
    b8.cfg_start = 1'b0; b8.pos_mode = 1'b0; b8.cfg_bit_valid = 1'b0; b8.cfg_bit = 1'b0;
    b8.in_valid = 1'b0; b8.in_vec = '0; b8.sweep_start = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", b3.out_valid, 0);
    chk("rst_out_f", b3.out_f, 0);
    chk("rst_out_vec", b3.out_vec, 0);
    chk("rst_tt_valid", b3.tt_valid, 0);
    chk("rst_cfg_done", b3.cfg_done, 0);
    chk("rst_sweep_busy", b3.sweep_busy, 0);
    chk("rst_sweep_done", b3.sweep_done, 0);
    rst = 1'b0;

    // Evaluation and sweep requests before any table is loaded
    b3.in_valid = 1'b1; b3.in_vec = 3'd3;
    #1;
    chk("noload_in_ready", b3.in_ready, 0);
    tick();
    chk("noload_out_valid", b3.out_valid, 0);
    b3.in_valid = 1'b0; b3.sweep_start = 1'b1;
    tick();
    b3.sweep_start = 1'b0;
    chk("noload_sweep_busy", b3.sweep_busy, 0);
    chk("noload_sweep_valid", b3.out_valid, 0);

    // POS, maxterms 0,1,3,5,7
    set_terms3(0, 1, 3, 5, 7);
    load3(1'b1, 1'b1, 0);
    sweep3();

    // SOP, same list, with gaps in cfg_bit_valid
    load3(1'b1, 1'b0, 50);
    sweep3();

    // Back-to-back evaluations: vec 3 then vec 2
    b3.in_valid = 1'b1; b3.in_vec = 3'd3;
    #1;
    chk("b2b_ready0", b3.in_ready, 1);
    tick();
    b3.in_vec = 3'd2;
    #1;
    chk("b2b_valid0", b3.out_valid, 1);
    chk("b2b_vec0", b3.out_vec, 3);
    chk("b2b_f0", b3.out_f, 1);
    chk("b2b_ready1", b3.in_ready, 1);
    tick();
    b3.in_valid = 1'b0;
    chk("b2b_valid1", b3.out_valid, 1);
    chk("b2b_vec1", b3.out_vec, 2);
    chk("b2b_f1", b3.out_f, 0);
    tick();
    chk("b2b_idle", b3.out_valid, 0);

    // Random tables with random evaluation traffic
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 8; i++) listed3[i] = 1'($urandom_range(1));
      load3(1'b1, 1'($urandom_range(1)), 30);
      for (int k = 0; k < 16; k++) begin
        int v = $urandom_range(7);
        bit iv = 1'($urandom_range(1));
        b3.in_valid = iv; b3.in_vec = 3'(v);
        #1;
        chk("rnd_ready", b3.in_ready, iv);
        tick();
        chk("rnd_valid", b3.out_valid, iv);
        if (iv) begin
          chk("rnd_vec", b3.out_vec, v);
          chk("rnd_f", b3.out_f, ref3(v));
        end
      end
      b3.in_valid = 1'b0;
      sweep3();
    end

    // cfg_start and sweep_start together: load wins
    set_terms3(2, 3, 4, 6, 6);
    b3.cfg_start = 1'b1; b3.sweep_start = 1'b1; b3.pos_mode = 1'b0;
    tick();
    b3.cfg_start = 1'b0; b3.sweep_start = 1'b0;
    chk("collide_busy", b3.sweep_busy, 0);
    chk("collide_valid", b3.out_valid, 0);
    chk("collide_tt", b3.tt_valid, 0);
    load3(1'b0, 1'b0, 0);
    sweep3();

    // Reset in the middle of a load
    b3.cfg_start = 1'b1; b3.pos_mode = 1'b1;
    tick();
    b3.cfg_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b3.cfg_bit_valid = 1'b1; b3.cfg_bit = 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstload_tt", b3.tt_valid, 0);
    chk("rstload_done", b3.cfg_done, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rstload_no_done", b3.cfg_done, 0);
    end
    b3.cfg_bit_valid = 1'b0;
    tick();
    chk("rstload_tt_after", b3.tt_valid, 0);
    set_terms3(1, 2, 4, 7, 7);
    load3(1'b1, 1'b0, 60);
    sweep3();

    // cfg_start while row 3 is on the output aborts the sweep
    b3.sweep_start = 1'b1;
    tick();
    b3.sweep_start = 1'b0;
    for (int r = 0; r < 3; r++) tick();
    chk("abort_row3_vec", b3.out_vec, 3);
    chk("abort_row3_f", b3.out_f, ref3(3));
    b3.cfg_start = 1'b1; b3.pos_mode = 1'b1;
    tick();
    b3.cfg_start = 1'b0;
    chk("abort_busy", b3.sweep_busy, 0);
    chk("abort_valid", b3.out_valid, 0);
    chk("abort_tt", b3.tt_valid, 0);
    chk("abort_no_done", b3.sweep_done, 0);
    set_terms3(0, 5, 6, 6, 6);
    load3(1'b0, 1'b1, 20);
    sweep3();

    // N_IN=8: 256-bit load and 256-row sweep
    pos8 = 1'($urandom_range(1));
    for (int i = 0; i < 256; i++) listed8[i] = 1'($urandom_range(1));
    b8.cfg_start = 1'b1; b8.pos_mode = pos8;
    tick();
    b8.cfg_start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      b8.cfg_bit_valid = 1'b1; b8.cfg_bit = listed8[i];
      tick();
      if (i == 254) chk("n8_cfg_done_early", b8.cfg_done, 0);
    end
    b8.cfg_bit_valid = 1'b0;
    chk("n8_cfg_done", b8.cfg_done, 1);
    chk("n8_tt_valid", b8.tt_valid, 1);
    b8.sweep_start = 1'b1;
    tick();
    b8.sweep_start = 1'b0;
    begin
      int ones8 = 0;
      for (int r = 0; r < 256; r++) begin
        chk("n8_row_valid", b8.out_valid, 1);
        chk("n8_row_vec", b8.out_vec, r);
        chk("n8_row_f", b8.out_f, ref8(r));
        if (r == 255) chk("n8_no_early_done", b8.sweep_done, 0);
        ones8 += ref8(r);
        tick();
      end
      chk("n8_done_at_257", b8.sweep_done, 1);
      chk("n8_busy_end", b8.sweep_busy, 0);
`ifdef LUT_GATE_ONES_COUNT_EN
      chk("n8_ones_cnt", 32'(b8.ones_cnt), ones8);
`endif
    end
    tick();
    chk("n8_done_pulse", b8.sweep_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lut_gate_seq.md
Name: lut_gate_seq

Overview:
- Parametrised, programmable N-input logic gate: the successor to the fixed 3-input hand-coded SOP/POS gates.
- The truth function is loaded serially at run time as a minterm mask (SOP mode) or a maxterm mask (POS mode).
- Single vectors are evaluated through a valid/ready handshake with a registered output.
- A built-in sweep engine emits the full truth table, one row per cycle, for bench and self-check use.

Parameters:
- N_IN, 3, number of gate inputs (1..8); table depth = 2**N_IN
- DEPTH, 2**N_IN, derived local parameter; not to be overridden

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- cfg_start  input  1  begin table load; latches pos_mode
- pos_mode  input  1  0 = mask lists minterms (F=1); 1 = mask lists maxterms (F=0)
- cfg_bit_valid  input  1  cfg_bit is valid this cycle
- cfg_bit  input  1  next mask bit, index 0 first
- cfg_done  output  1  one-cycle pulse when the last mask bit is accepted
- tt_valid  output  1  a complete table is loaded
- in_valid  input  1  evaluation request
- in_vec  input  N_IN  input combination; bit N_IN-1 = A (MSB)
- in_ready  output  1  evaluation accepted this cycle
- sweep_start  input  1  start a full-table sweep
- sweep_busy  output  1  sweep in progress
- sweep_done  output  1  one-cycle pulse after the last sweep row
- out_valid  output  1  out_f/out_vec valid; one-cycle pulse, no backpressure
- out_vec  output  N_IN  combination that produced out_f
- out_f  output  1  function value

Behaviour:
- Reset: all outputs 0, mask 0, tt_valid 0, state IDLE, counters 0. Reset mid-load or mid-sweep aborts with no done pulse.
- FSM states: IDLE, LOAD, SWEEP.
- Command priority, evaluated in any state: cfg_start > sweep_start > in_valid.
- cfg_start, any state:
  - go to LOAD, clear bit counter, tt_valid <= 0, latch pos_mode.
  - An active sweep aborts: sweep_busy drops, no sweep_done.
  - cfg_start in LOAD restarts the load.
- LOAD:
  - each cycle with cfg_bit_valid: mask[cnt] <= cfg_bit, cnt++.
  - On the bit at cnt == DEPTH-1: next cycle cfg_done=1, tt_valid=1, state IDLE.
  - Gaps in cfg_bit_valid are allowed. in_ready=0.
- Function: F(i) = mask[i] XOR pos_latched. Example: maxterms 0,1,3,5,7 give mask 8'hAB, so F=1 only at 2, 4, 6.
- IDLE evaluation:
  - in_ready = in_valid & tt_valid & no cfg_start & no sweep_start.
  - On accept, the next cycle has out_valid=1, out_vec=in_vec, out_f=F(in_vec). Latency 1.
  - Back-to-back accepts are allowed, one per cycle.
  - in_valid with tt_valid=0 is never accepted (in_ready stays 0).
- sweep_start in IDLE:
  - With tt_valid=1: go to SWEEP, row counter 0. Otherwise ignored.
  - sweep_start while already in SWEEP is ignored.
- SWEEP:
  - sweep_busy=1. Each cycle emits row r: out_valid=1, out_vec=r, out_f=F(r), for r = 0..DEPTH-1 on DEPTH consecutive cycles.
  - The first row appears the cycle after sweep_start.
  - The row counter wraps DEPTH-1 -> 0 internally. The cycle after the last row: sweep_done=1, sweep_busy=0, state IDLE.
  - in_ready=0 during SWEEP.
- All counters are N_IN+1 bits wide, so the N_IN=8 terminal count is exact.

Optional Feature:
- Macro: LUT_GATE_ONES_COUNT_EN.
- Defined:
  - adds output ones_cnt [N_IN:0], cleared at sweep start.
  - Increments for each sweep row with F=1.
  - Holds its final value from the sweep_done cycle until the next sweep_start, cfg_start or rst.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package lut_gate_pkg: state enum (IDLE, LOAD, SWEEP), default N_IN constant, depth function.
- One sub-module, lut_gate_eval: purely combinational, mask + pos flag + vector -> F. It is shared by the evaluation and sweep paths.

Test Plan:
- Load in POS mode, mask 8'hAB, N_IN=3 -> cfg_done pulse after 8th bit, tt_valid=1. Sweep outputs F = 0,0,1,0,1,0,1,0 for rows 0..7, then sweep_done. ones_cnt=3 if the macro is enabled.
- Same mask, SOP mode -> sweep F = 1,1,0,1,0,1,0,1. Back-to-back evaluations of vec 3 then vec 2 -> out_f 1 then 0 on consecutive cycles, each one cycle after accept.
- in_valid before any load -> in_ready=0, no out_valid. cfg_start and sweep_start in the same cycle -> LOAD entered, no sweep.
- Load interrupted at bit 4 by rst -> tt_valid=0, cfg_done never pulses. A fresh load with cfg_bit_valid gaps completes correctly.
- cfg_start at sweep row 3 -> sweep aborts with no sweep_done, tt_valid=0 until the reload completes.
- N_IN=8 -> 256-bit load, 256-row sweep, sweep_done exactly 257 cycles after sweep_start.
